pcs_mdio_mmd3: RTL

Clause 45 MDIO slave and PCS register file (MMD 3) that sits directly upstream of the 40G PCS wrapper's management pins. It decodes serial MDIO frames and drives the wrapper's reset, loopback, tx_test_mode and rx_test_mode controls. It also reads back the wrapper's status and counter outputs, and adds the missing clear-on-read behaviour for `test_pattern_error_count` and the other counters without modifying the PCS core.

---
 rtl/pcs_mdio_pkg.sv | 33 +++
 rtl/mdio_frame_fsm.sv | 153 +++++++++++++++
 rtl/pcs_mdio_mmd3.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pcs_mdio_pkg.sv
// Shared constants, opcodes, register addresses and the frame FSM state type for the MMD 3 MDIO slave.
package pcs_mdio_pkg;

    localparam logic [1:0] OP_ADDR     = 2'b00;
    localparam logic [1:0] OP_WRITE    = 2'b01;
    localparam logic [1:0] OP_READ_INC = 2'b10;
    localparam logic [1:0] OP_READ     = 2'b11;

    localparam logic [4:0] DEVAD_PCS     = 5'd3;
    localparam logic [5:0] PREAMBLE_ONES = 6'd32;

    localparam logic [15:0] ADDR_CTRL1       = 16'd0;
    localparam logic [15:0] ADDR_STAT1       = 16'd1;
    localparam logic [15:0] ADDR_BASER_STAT1 = 16'd32;
    localparam logic [15:0] ADDR_BASER_STAT2 = 16'd33;
    localparam logic [15:0] ADDR_TEST_CTRL   = 16'd42;
    localparam logic [15:0] ADDR_TEST_ERR    = 16'd43;
    localparam logic [15:0] ADDR_ALIGN_STAT  = 16'd50;
    localparam logic [15:0] ADDR_AM_LOCK     = 16'd52;
    localparam logic [15:0] ADDR_BIP0        = 16'd200;
    localparam logic [15:0] ADDR_LANE_MAP0   = 16'd400;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_OP,
        ST_PRTAD,
        ST_DEVAD,
        ST_TA,
        ST_DATA
    } mdioState_e;

endpackage

// File: rtl/mdio_frame_fsm.sv
// Clause 45 frame engine: preamble hunt, field capture, turnaround and serial read-data drive.
module mdio_frame_fsm
    import pcs_mdio_pkg::*;
#(
    parameter logic [4:0] PRTAD = 5'd0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        mdio_i,
    input  logic [15:0] rdData_i,
    output logic        mdioOut_o,
    output logic        mdioOe_o,
    output logic        addrStb_o,
    output logic        wrStb_o,
    output logic        rdSnap_o,
    output logic        rdDone_o,
    output logic        rdInc_o,
    output logic [15:0] data_o
);

    mdioState_e  state_q, state_d;
    logic [3:0]  bitCnt_q, bitCnt_d;
    logic [5:0]  onesCnt_q, onesCnt_d;
    logic [15:0] shift_q, shift_d;
    logic [15:0] tx_q, tx_d;
    logic [1:0]  op_q, op_d;
    logic        prtadOk_q, prtadOk_d;
    logic        accept_q, accept_d;
    logic        oe_q, oe_d;
    logic        out_q, out_d;
    logic [4:0]  field;
    logic        isRead;

    assign field  = shift_d[4:0];
    assign isRead = accept_q && op_q[1];

    always_comb begin
        state_d   = state_q;
        bitCnt_d  = bitCnt_q + 4'd1;
        onesCnt_d = onesCnt_q;
        shift_d   = {shift_q[14:0], mdio_i};
        tx_d      = tx_q;
        op_d      = op_q;
        prtadOk_d = prtadOk_q;
        accept_d  = accept_q;
        oe_d      = oe_q;
        out_d     = out_q;
        addrStb_o = 1'b0;
        wrStb_o   = 1'b0;
        rdSnap_o  = 1'b0;
        rdDone_o  = 1'b0;
        rdInc_o   = 1'b0;
        data_o    = shift_d;
        case (state_q)
            ST_IDLE: begin
                bitCnt_d = '0;
                if (mdio_i) begin
                    onesCnt_d = (onesCnt_q == PREAMBLE_ONES) ? onesCnt_q : onesCnt_q + 6'd1;
                end else begin
                    onesCnt_d = '0;
                    if (onesCnt_q == PREAMBLE_ONES) state_d = ST_START;
                end
            end
            ST_START: begin
                bitCnt_d = '0;
                state_d  = mdio_i ? ST_IDLE : ST_OP;
            end
            ST_OP: if (bitCnt_q == 4'd1) begin
                op_d     = field[1:0];
                state_d  = ST_PRTAD;
                bitCnt_d = '0;
            end
            ST_PRTAD: if (bitCnt_q == 4'd4) begin
                prtadOk_d = (field == PRTAD);
                state_d   = ST_DEVAD;
                bitCnt_d  = '0;
            end
            ST_DEVAD: if (bitCnt_q == 4'd4) begin
                accept_d = prtadOk_q && (field == DEVAD_PCS);
                rdSnap_o = accept_d && op_q[1];
                state_d  = ST_TA;
                bitCnt_d = '0;
            end
            ST_TA: begin
                if (bitCnt_q == 4'd0) begin
                    if (isRead) begin
                        oe_d  = 1'b1;
                        out_d = 1'b0;
                    end
                end else begin
                    state_d  = ST_DATA;
                    bitCnt_d = '0;
                    if (isRead) begin
                        out_d = rdData_i[15];
                        tx_d  = {rdData_i[14:0], 1'b0};
                    end
                end
            end
            ST_DATA: begin
                if (bitCnt_q == 4'd15) begin
                    state_d  = ST_IDLE;
                    bitCnt_d = '0;
                    oe_d     = 1'b0;
                    out_d    = 1'b1;
                    if (accept_q) begin
                        case (op_q)
                            OP_ADDR:  addrStb_o = 1'b1;
                            OP_WRITE: wrStb_o   = 1'b1;
                            default: begin
                                rdDone_o = 1'b1;
                                rdInc_o  = (op_q == OP_READ_INC);
                            end
                        endcase
                    end
                end else if (oe_q) begin
                    out_d = tx_q[15];
                    tx_d  = {tx_q[14:0], 1'b0};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            bitCnt_q  <= '0;
            onesCnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= '0;
            op_q      <= '0;
            prtadOk_q <= 1'b0;
            accept_q  <= 1'b0;
            oe_q      <= 1'b0;
            out_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            bitCnt_q  <= bitCnt_d;
            onesCnt_q <= onesCnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            op_q      <= op_d;
            prtadOk_q <= prtadOk_d;
            accept_q  <= accept_d;
            oe_q      <= oe_d;
            out_q     <= out_d;
        end
    end

    assign mdioOut_o = out_q;
    assign mdioOe_o  = oe_q;

endmodule

// File: rtl/pcs_mdio_mmd3.sv
// MMD 3 register file behind a Clause 45 MDIO slave for the 40G PCS wrapper.
// Define PCS_MDIO_CLEAR_ON_READ_EN to build baseline registers giving clear-on-read counters.
module pcs_mdio_mmd3
    import pcs_mdio_pkg::*;
#(
    parameter logic [4:0] PRTAD            = 5'd0,
    parameter int         PCS_RESET_CYCLES = 16
) (
    input  logic        MDC,
    input  logic        reset,
    input  logic        MDIO_IN,
    output logic        MDIO_OUT,
    output logic        MDIO_OE,
    output logic        pcs_reset,
    output logic        loopback,
    output logic        tx_test_mode,
    output logic        rx_test_mode,
    input  logic        PCS_status,
    input  logic        hi_ber,
    input  logic        align_status,
    input  logic [3:0]  block_lock,
    input  logic [3:0]  am_lock,
    input  logic [21:0] ber_count,
    input  logic [21:0] errored_block_count,
    input  logic [15:0] test_pattern_error_count,
    input  logic [63:0] bip_counters,
    input  logic [7:0]  lane_mapping
);

    localparam int RCW = $clog2(PCS_RESET_CYCLES + 1);

    logic        addrStb, wrStb, rdSnap, rdDone, rdInc;
    logic [15:0] fsmData, rdMux, snapData_q, addr_q;
    logic [10:0] sync1_q, sync2_q;
    logic        loopback_q, txTest_q, rxTest_q, linkLatch_q;
    logic [RCW-1:0] rstCnt_q;
    logic        linkLive, hiBerSync, alignSync;
    logic [3:0]  blockLockSync, amLockSync;
    logic [5:0]  berOut;
    logic [7:0]  ebcOut;
    logic [15:0] tpeOut;
    logic [15:0] bipLive [4];
    logic [15:0] bipOut [4];
    logic        unusedBits;

    mdio_frame_fsm #(.PRTAD(PRTAD)) uFsm (
        .clk_i     (MDC),
        .reset_i   (reset),
        .mdio_i    (MDIO_IN),
        .rdData_i  (snapData_q),
        .mdioOut_o (MDIO_OUT),
        .mdioOe_o  (MDIO_OE),
        .addrStb_o (addrStb),
        .wrStb_o   (wrStb),
        .rdSnap_o  (rdSnap),
        .rdDone_o  (rdDone),
        .rdInc_o   (rdInc),
        .data_o    (fsmData)
    );

    assign {linkLive, hiBerSync, alignSync, blockLockSync, amLockSync} = sync2_q;
    assign unusedBits = ^{ber_count[21:6], errored_block_count[21:8]};

    always_comb begin
        for (int n = 0; n < 4; n++) bipLive[n] = bip_counters[16*n +: 16];
    end

`ifdef PCS_MDIO_CLEAR_ON_READ_EN
    logic [5:0]  baseBer_q;
    logic [7:0]  baseEbc_q;
    logic [15:0] baseTpe_q, snapLive_q, liveMux;
    logic [15:0] baseBip_q [4];

    always_comb begin
        liveMux = '0;
        case (addr_q)
            ADDR_BASER_STAT2: liveMux = {2'b00, ber_count[5:0], errored_block_count[7:0]};
            ADDR_TEST_ERR:    liveMux = test_pattern_error_count;
            default:          liveMux = '0;
        endcase
        for (int n = 0; n < 4; n++) begin
            if (addr_q == ADDR_BIP0 + 16'(n)) liveMux = bipLive[n];
        end
        berOut = ber_count[5:0] - baseBer_q;
        ebcOut = errored_block_count[7:0] - baseEbc_q;
        tpeOut = test_pattern_error_count - baseTpe_q;
        for (int n = 0; n < 4; n++) bipOut[n] = bipLive[n] - baseBip_q[n];
    end

    // Baselines move to the value the reader actually saw, not the value at frame end.
    always_ff @(posedge MDC) begin
        if (reset) begin
            baseBer_q  <= '0;
            baseEbc_q  <= '0;
            baseTpe_q  <= '0;
            snapLive_q <= '0;
            for (int n = 0; n < 4; n++) baseBip_q[n] <= '0;
        end else begin
            if (rdSnap) snapLive_q <= liveMux;
            if (rdDone) begin
                if (addr_q == ADDR_BASER_STAT2) begin
                    baseBer_q <= snapLive_q[13:8];
                    baseEbc_q <= snapLive_q[7:0];
                end
                if (addr_q == ADDR_TEST_ERR) baseTpe_q <= snapLive_q;
                for (int n = 0; n < 4; n++) begin
                    if (addr_q == ADDR_BIP0 + 16'(n)) baseBip_q[n] <= snapLive_q;
                end
            end
        end
    end
`else
    always_comb begin
        berOut = ber_count[5:0];
        ebcOut = errored_block_count[7:0];
        tpeOut = test_pattern_error_count;
        for (int n = 0; n < 4; n++) bipOut[n] = bipLive[n];
    end
`endif

    always_comb begin
        rdMux = '0;
        case (addr_q)
            ADDR_CTRL1:       rdMux = {pcs_reset, loopback_q, 14'b0};
            ADDR_STAT1:       rdMux = {13'b0, linkLatch_q, 2'b00};
            ADDR_BASER_STAT1: rdMux = {3'b000, linkLive, 10'b0, hiBerSync, &blockLockSync};
            ADDR_BASER_STAT2: rdMux = {2'b00, berOut, ebcOut};
            ADDR_TEST_CTRL:   rdMux = {12'b0, txTest_q, rxTest_q, 2'b00};
            ADDR_TEST_ERR:    rdMux = tpeOut;
            ADDR_ALIGN_STAT:  rdMux = {3'b000, alignSync, 8'b0, blockLockSync};
            ADDR_AM_LOCK:     rdMux = {12'b0, amLockSync};
            default:          rdMux = '0;
        endcase
        for (int n = 0; n < 4; n++) begin
            if (addr_q == ADDR_BIP0 + 16'(n))      rdMux = bipOut[n];
            if (addr_q == ADDR_LANE_MAP0 + 16'(n)) rdMux = {14'b0, lane_mapping[2*n +: 2]};
        end
    end

    // A latch-low event on the re-arm edge still clears the bit because linkLive is 0 then.
    always_ff @(posedge MDC) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            snapData_q  <= '0;
            addr_q      <= '0;
            loopback_q  <= 1'b0;
            txTest_q    <= 1'b0;
            rxTest_q    <= 1'b0;
            linkLatch_q <= 1'b0;
            rstCnt_q    <= '0;
        end else begin
            sync1_q     <= {PCS_status, hi_ber, align_status, block_lock, am_lock};
            sync2_q     <= sync1_q;
            linkLatch_q <= linkLatch_q & linkLive;
            if (rdSnap) snapData_q <= rdMux;
            if (rstCnt_q != '0) rstCnt_q <= rstCnt_q - RCW'(1);
            if (addrStb) addr_q <= fsmData;
            if (wrStb) begin
                if (addr_q == ADDR_CTRL1) begin
                    loopback_q <= fsmData[14];
                    if (fsmData[15]) rstCnt_q <= RCW'(PCS_RESET_CYCLES);
                end
                if (addr_q == ADDR_TEST_CTRL) begin
                    txTest_q <= fsmData[3];
                    rxTest_q <= fsmData[2];
                end
            end
            if (rdDone) begin
                if (rdInc) addr_q <= addr_q + 16'd1;
                if (addr_q == ADDR_STAT1) linkLatch_q <= linkLive;
            end
        end
    end

    assign pcs_reset    = (rstCnt_q != '0);
    assign loopback     = loopback_q;
    assign tx_test_mode = txTest_q;
    assign rx_test_mode = rxTest_q;

endmodule
